// File: rtl/decimating_averager.sv
// Decimating averager: emits the mean of every factor_p accepted samples on a
// registered ready/valid output. Define DECIMATING_AVERAGER_ROUND_EN for round-half-up.
module decimating_averager #(
  parameter int unsigned width_p  = 8,
  parameter int unsigned factor_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               flush_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  localparam int unsigned shift_lp = $clog2(factor_p);
  localparam int unsigned acc_w_lp = width_p + shift_lp;
  localparam logic [shift_lp-1:0] cnt_last_lp = shift_lp'(factor_p - 1);

  logic [acc_w_lp-1:0] acc_reg, acc_next;
  logic [shift_lp-1:0] cnt_reg, cnt_next;
  logic [width_p-1:0]  data_reg, data_next;
  logic                valid_reg, valid_next;

  logic [acc_w_lp-1:0] sum;
  logic [width_p-1:0]  mean;
  logic                last_slot;
  logic                accept;
  logic                complete;

  // Only the group-completing sample can be blocked: it needs the output register free.
  assign last_slot = (cnt_reg == cnt_last_lp);
  assign ready_o   = !flush_i && !(last_slot && valid_reg && !ready_i);
  assign accept    = valid_i && ready_o;
  assign complete  = accept && last_slot;

  // acc carries shift_lp extra bits, so the full group sum never overflows.
  assign sum = acc_reg + {{shift_lp{1'b0}}, data_i};

`ifdef DECIMATING_AVERAGER_ROUND_EN
  // One guard bit keeps the half-LSB addition exact before the shift.
  localparam logic [acc_w_lp:0] half_lp = (acc_w_lp + 1)'(1) << (shift_lp - 1);
  logic [acc_w_lp:0] sum_rnd;
  assign sum_rnd = {1'b0, sum} + half_lp;
  assign mean    = width_p'(sum_rnd >> shift_lp);
`else
  assign mean = width_p'(sum >> shift_lp);
`endif

  always_comb begin
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    if (valid_reg && ready_i) begin
      valid_next = 1'b0;
    end
    if (flush_i) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (complete) begin
      acc_next   = '0;
      cnt_next   = '0;
      data_next  = mean;
      valid_next = 1'b1;
    end else if (accept) begin
      acc_next = sum;
      cnt_next = cnt_reg + shift_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  assign data_o  = data_reg;
  assign valid_o = valid_reg;

endmodule

// File: tb/tb_decimating_averager.sv
// Bench for decimating_averager (width_p=8, factor_p=4): directed scenarios plus a
// group-level model checked against the DUT every cycle.
module tb_decimating_averager;

  localparam int W = 8;
  localparam int F = 4;

  logic         clk_i    = 1'b0;
  logic         reset_ni = 1'b0;
  logic         flush_i  = 1'b0;
  logic [W-1:0] data_i   = '0;
  logic         valid_i  = 1'b0;
  logic         ready_i  = 1'b1;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         valid_o;

  decimating_averager #(.width_p(W), .factor_p(F)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .flush_i (flush_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_hs   = 0;

  // Model: samples of the current group, plus the one pending output mean.
  int grp_sum   = 0;
  int grp_n     = 0;
  bit exp_valid = 1'b0;
  int exp_data  = 0;

  function automatic int model_mean(int s);
`ifdef DECIMATING_AVERAGER_ROUND_EN
    return (s + F / 2) / F;
`else
    return s / F;
`endif
  endfunction

  function automatic bit model_ready();
    return !flush_i && !(grp_n == F - 1 && exp_valid && !ready_i);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial begin
    bit rdy;
    forever begin
      @(posedge clk_i or negedge reset_ni);
      if (!reset_ni) begin
        grp_sum   = 0;
        grp_n     = 0;
        exp_valid = 1'b0;
        exp_data  = 0;
      end else begin
        rdy = model_ready();
        if (exp_valid && ready_i) exp_valid = 1'b0;
        if (flush_i) begin
          grp_sum = 0;
          grp_n   = 0;
        end else if (valid_i && rdy) begin
          grp_sum += int'(data_i);
          grp_n++;
          if (grp_n == F) begin
            exp_data  = model_mean(grp_sum);
            exp_valid = 1'b1;
            grp_sum   = 0;
            grp_n     = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_data_o", int'(data_o), 0);
      end else begin
        chk("model_valid_o", int'(valid_o), int'(exp_valid));
        if (exp_valid) chk("model_data_o", int'(data_o), exp_data);
        chk("model_ready_o", int'(ready_o), int'(model_ready()));
        if (valid_o && ready_i) dut_hs++;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input int d);
    valid_i = 1'b1;
    data_i  = W'(d);
    #1;
    chk("send_ready_o", int'(ready_o), 1);
    step();
  endtask

  int exp_rnd;
  int hs0;

  initial begin
`ifdef DECIMATING_AVERAGER_ROUND_EN
    exp_rnd = 2;
`else
    exp_rnd = 1;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_valid_o", int'(valid_o), 0);
    chk("reset_data_o", int'(data_o), 0);
    chk("reset_ready_o", int'(ready_o), 1);
    #2 reset_ni = 1'b1;
    step();

    // Basic average
    send(10); send(20); send(30); send(40);
    valid_i = 1'b0;
    #1;
    chk("basic_valid", int'(valid_o), 1);
    chk("basic_data", int'(data_o), 25);
    step();
    chk("basic_valid_drop", int'(valid_o), 0);

    // Rounding and full-scale
    send(1); send(2); send(2); send(1);
    valid_i = 1'b0;
    #1;
    chk("round_data", int'(data_o), exp_rnd);
    step();
    send(255); send(255); send(255); send(255);
    valid_i = 1'b0;
    #1;
    chk("max_data", int'(data_o), 255);
    step();

    // Backpressure
    ready_i = 1'b0;
    send(10); send(20); send(30); send(40);
    valid_i = 1'b0;
    #1;
    chk("bp_held_data", int'(data_o), 25);
    send(4); send(4); send(4);
    valid_i = 1'b1;
    data_i  = 8'd8;
    #1;
    chk("bp_stall_ready", int'(ready_o), 0);
    step(); step();
    chk("bp_still_held", int'(data_o), 25);
    chk("bp_still_valid", int'(valid_o), 1);
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready", int'(ready_o), 1);
    step();
    valid_i = 1'b0;
    #1;
    chk("bp_no_bubble", int'(valid_o), 1);
    chk("bp_next_data", int'(data_o), 5);
    step();
    chk("bp_drained", int'(valid_o), 0);

    // Flush
    send(100); send(100);
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'd77;
    #1;
    chk("flush_ready", int'(ready_o), 0);
    step();
    flush_i = 1'b0;
    send(4); send(8); send(12); send(16);
    valid_i = 1'b0;
    #1;
    chk("flush_valid", int'(valid_o), 1);
    chk("flush_data", int'(data_o), 10);
    step();

    // Asynchronous reset with an output pending and a partial group
    ready_i = 1'b0;
    send(8); send(8); send(8); send(8);
    send(50); send(50);
    valid_i = 1'b0;
    #1;
    chk("pre_rst_data", int'(data_o), 8);
    #2 reset_ni = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid_o), 0);
    chk("async_rst_data", int'(data_o), 0);
    step(); step();
    #2 reset_ni = 1'b1;
    ready_i = 1'b1;
    step();
    send(2); send(2); send(2); send(2);
    valid_i = 1'b0;
    #1;
    chk("post_rst_valid", int'(valid_o), 1);
    chk("post_rst_data", int'(data_o), 2);
    step();

    // Gapped input
    hs0 = dut_hs;
    for (int i = 0; i < 4; i++) begin
      send(40);
      valid_i = 1'b0;
      if (i < 3) begin
        repeat (3) step();
      end
    end
    #1;
    chk("gap_valid", int'(valid_o), 1);
    chk("gap_data", int'(data_o), 40);
    repeat (6) step();
    chk("gap_output_count", dut_hs - hs0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
